// File: rtl/hazard_ctrl_if.sv
// Opcode/encoding package shared by the hazard scheduler and its users,
// followed by the ID-side interface bundle.
//
// hazard_ctrl_if ports (signals):
//   id_valid, id_opcode[5:0], flush      : ID stage -> scheduler
//   fwd_a_sel[1:0], fwd_b_sel[1:0]       : EX operand source selects
//   stall, bubble, stall_count[CNT_W-1:0]: pipeline control / debug
// Modports: master = pipeline side, slave = hazard_ctrl.

package hazard_ctrl_pkg;
  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_LDA   = 6'h01;
  localparam logic [5:0] OP_LDCA  = 6'h02;
  localparam logic [5:0] OP_ADDA  = 6'h03;
  localparam logic [5:0] OP_ADDCA = 6'h04;
  localparam logic [5:0] OP_SUBA  = 6'h05;
  localparam logic [5:0] OP_SUBCA = 6'h06;
  localparam logic [5:0] OP_ANDA  = 6'h07;
  localparam logic [5:0] OP_ANDCA = 6'h08;
  localparam logic [5:0] OP_ORA   = 6'h09;
  localparam logic [5:0] OP_ORCA  = 6'h0A;
  localparam logic [5:0] OP_ASLA  = 6'h0B;
  localparam logic [5:0] OP_ASRA  = 6'h0C;
  localparam logic [5:0] OP_STA   = 6'h0D;
  localparam logic [5:0] OP_LDB   = 6'h11;
  localparam logic [5:0] OP_LDCB  = 6'h12;
  localparam logic [5:0] OP_ADDB  = 6'h13;
  localparam logic [5:0] OP_ADDCB = 6'h14;
  localparam logic [5:0] OP_SUBB  = 6'h15;
  localparam logic [5:0] OP_SUBCB = 6'h16;
  localparam logic [5:0] OP_ANDB  = 6'h17;
  localparam logic [5:0] OP_ANDCB = 6'h18;
  localparam logic [5:0] OP_ORB   = 6'h19;
  localparam logic [5:0] OP_ORCB  = 6'h1A;
  localparam logic [5:0] OP_STB   = 6'h1D;

  localparam logic [1:0] DST_NONE = 2'd0;
  localparam logic [1:0] DST_A    = 2'd1;
  localparam logic [1:0] DST_B    = 2'd2;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
endpackage

interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic             flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_opcode, flush,
    input  fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
  );

  modport slave (
    input  id_valid, id_opcode, flush,
    output fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding scheduler for the A/B accumulator
// five-stage pipeline. Decodes the ID opcode, tracks the accumulator
// destinations of the EX and MEM instructions, and produces registered
// EX-stage forwarding selects, a combinational load-use stall, a bubble
// flag and a saturating stall counter.
//
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : synchronous active-high reset
//   hz   : hazard_ctrl_if.slave (id_valid, id_opcode, flush in;
//          fwd_a_sel, fwd_b_sel, stall, bubble, stall_count out)

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  // Decode bundle: {wr_a, rd_a, wr_b, rd_b, load}
  function automatic logic [4:0] decode(input logic [5:0] op);
    logic [4:0] d;
    case (op)
      OP_LDA:                               d = 5'b10001;
      OP_LDCA:                              d = 5'b10000;
      OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA,
      OP_ANDA, OP_ANDCA, OP_ORA,  OP_ORCA,
      OP_ASLA, OP_ASRA:                     d = 5'b11000;
      OP_STA:                               d = 5'b01000;
      OP_LDB:                               d = 5'b00101;
      OP_LDCB:                              d = 5'b00100;
      OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB,
      OP_ANDB, OP_ANDCB, OP_ORB,  OP_ORCB:  d = 5'b00110;
      OP_STB:                               d = 5'b00010;
      default:                              d = 5'b00000;
    endcase
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [4:0]       dec;
  logic             wr_a, rd_a, wr_b, rd_b, is_load;
  logic [1:0]       id_dst;
  logic             stall;

  logic [1:0]       ex_dst_q, ex_dst_d;
  logic             ex_ld_q, ex_ld_d;
  logic [1:0]       mem_dst_q, mem_dst_d;
  logic             bubble_q, bubble_d;
  logic [1:0]       fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0]       fwd_b_sel_q, fwd_b_sel_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // An invalid ID slot decodes as a NOP: no reads, no writes.
  assign dec = hz.id_valid ? decode(hz.id_opcode) : 5'b00000;
  assign {wr_a, rd_a, wr_b, rd_b, is_load} = dec;
  assign id_dst = wr_a ? DST_A : (wr_b ? DST_B : DST_NONE);

  // Load results exist only at the end of MEM, so a dependent consumer
  // in ID must wait one cycle. A flush squashes the consumer instead.
  assign stall = hz.id_valid & ~hz.flush & ex_ld_q &
                 ((rd_a & (ex_dst_q == DST_A)) | (rd_b & (ex_dst_q == DST_B)));

  always_comb begin
    mem_dst_d     = ex_dst_q;
    ex_dst_d      = id_dst;
    ex_ld_d       = is_load;
    bubble_d      = ~hz.id_valid;
    fwd_a_sel_d   = FWD_REG;
    fwd_b_sel_d   = FWD_REG;
    stall_count_d = stall ? sat_inc(stall_count_q) : stall_count_q;

    if (stall || hz.flush) begin
      ex_dst_d = DST_NONE;
      ex_ld_d  = 1'b0;
      bubble_d = 1'b1;
    end else begin
      // Youngest producer wins: EX/MEM beats MEM/WB. A load in EX is never
      // forwarded from EX/MEM (the stall above covers that case).
      if (rd_a) begin
        if (ex_dst_q == DST_A && !ex_ld_q) fwd_a_sel_d = FWD_EXMEM;
        else if (mem_dst_q == DST_A)       fwd_a_sel_d = FWD_MEMWB;
      end
      if (rd_b) begin
        if (ex_dst_q == DST_B && !ex_ld_q) fwd_b_sel_d = FWD_EXMEM;
        else if (mem_dst_q == DST_B)       fwd_b_sel_d = FWD_MEMWB;
      end
    end
  end

  // ID -> EX / EX -> MEM boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_dst_q      <= DST_NONE;
      ex_ld_q       <= 1'b0;
      mem_dst_q     <= DST_NONE;
      bubble_q      <= 1'b0;
      fwd_a_sel_q   <= FWD_REG;
      fwd_b_sel_q   <= FWD_REG;
      stall_count_q <= '0;
    end else begin
      ex_dst_q      <= ex_dst_d;
      ex_ld_q       <= ex_ld_d;
      mem_dst_q     <= mem_dst_d;
      bubble_q      <= bubble_d;
      fwd_a_sel_q   <= fwd_a_sel_d;
      fwd_b_sel_q   <= fwd_b_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.stall       = stall;
  assign hz.bubble      = bubble_q;
  assign hz.fwd_a_sel   = fwd_a_sel_q;
  assign hz.fwd_b_sel   = fwd_b_sel_q;
  assign hz.stall_count = stall_count_q;

endmodule
